// File: rtl/dat_loader.sv
// dat_loader: bus initiator that programs one DAT task window on the MMU card,
// optionally reads it back, then activates the task and writes INIT0.
module dat_loader #(
    parameter int ENTRIES = 16,
    parameter bit VERIFY  = 1'b1
) (
    input  logic        e,
    input  logic        _reset,
    input  logic        start,
    input  logic [11:0] task_id,
    input  logic        mmu_en,
    input  logic        crm_en,
    input  logic [7:0]  src_data,
    input  logic        src_valid,
    output logic        src_ready,
    output logic [15:0] address_cpu,
    output logic        r_w_cpu,
    output logic [7:0]  data_wr,
    input  logic [7:0]  data_rd,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [3:0]  fail_index
);
    localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam logic [IW-1:0] LAST = IW'(ENTRIES - 1);

    typedef enum logic [3:0] {
        IDLE, SEL_LO, SEL_HI, LD_WAIT, LD_WR, RD, ACT_LO, ACT_HI, INIT0, DONE
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [11:0]   task_q;
    logic          mmu_q;
    logic          crm_q;
    logic [7:0]    shadow [ENTRIES];

    function automatic logic [15:0] win_addr(input logic [IW-1:0] i);
        return {12'hFFA, 4'(i)};
    endfunction

    // Shadow copy of every loaded byte, used as the reference during read-back.
    always_ff @(posedge e) begin
        if (state == LD_WAIT && src_valid)
            shadow[idx] <= src_data;
    end

    // Outputs are set for the state being entered, so they describe the bus
    // activity of the coming e period.
    always_ff @(posedge e) begin
        if (!_reset) begin
            state       <= IDLE;
            address_cpu <= 16'h0000;
            r_w_cpu     <= 1'b1;
            data_wr     <= 8'h00;
            src_ready   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            fail_index  <= 4'h0;
            idx         <= '0;
            task_q      <= 12'h000;
            mmu_q       <= 1'b0;
            crm_q       <= 1'b0;
        end else begin
            address_cpu <= 16'h0000;
            r_w_cpu     <= 1'b1;
            data_wr     <= 8'h00;
            src_ready   <= 1'b0;
            done        <= 1'b0;
            unique case (state)
                IDLE: if (start) begin
                    state       <= SEL_LO;
                    busy        <= 1'b1;
                    error       <= 1'b0;
                    fail_index  <= 4'h0;
                    idx         <= '0;
                    task_q      <= task_id;
                    mmu_q       <= mmu_en;
                    crm_q       <= crm_en;
                    address_cpu <= 16'hFF91;
                    r_w_cpu     <= 1'b0;
                    data_wr     <= {3'b100, task_id[4:0]};
                end
                SEL_LO: begin
                    state       <= SEL_HI;
                    address_cpu <= 16'hFF97;
                    r_w_cpu     <= 1'b0;
                    data_wr     <= {1'b0, task_q[11:5]};
                end
                SEL_HI: begin
                    state     <= LD_WAIT;
                    src_ready <= 1'b1;
                end
                LD_WAIT: if (src_valid) begin
                    state       <= LD_WR;
                    address_cpu <= win_addr(idx);
                    r_w_cpu     <= 1'b0;
                    data_wr     <= src_data;
                end else begin
                    src_ready <= 1'b1;
                end
                LD_WR: if (idx == LAST) begin
                    idx <= '0;
                    if (VERIFY) begin
                        state       <= RD;
                        address_cpu <= win_addr('0);
                    end else begin
                        state       <= ACT_LO;
                        address_cpu <= 16'hFF91;
                        r_w_cpu     <= 1'b0;
                        data_wr     <= {3'b000, task_q[4:0]};
                    end
                end else begin
                    idx       <= idx + IW'(1);
                    state     <= LD_WAIT;
                    src_ready <= 1'b1;
                end
                RD: if (data_rd != shadow[idx]) begin
                    error      <= 1'b1;
                    fail_index <= 4'(idx);
                    state      <= DONE;
                    done       <= 1'b1;
                    busy       <= 1'b0;
                end else if (idx == LAST) begin
                    state       <= ACT_LO;
                    address_cpu <= 16'hFF91;
                    r_w_cpu     <= 1'b0;
                    data_wr     <= {3'b000, task_q[4:0]};
                end else begin
                    idx         <= idx + IW'(1);
                    address_cpu <= win_addr(idx + IW'(1));
                end
                ACT_LO: begin
                    state       <= ACT_HI;
                    address_cpu <= 16'hFF97;
                    r_w_cpu     <= 1'b0;
                    data_wr     <= {1'b0, task_q[11:5]};
                end
                ACT_HI: begin
                    state       <= INIT0;
                    address_cpu <= 16'hFF90;
                    r_w_cpu     <= 1'b0;
                    data_wr     <= {1'b0, mmu_q, 2'b00, crm_q, 3'b000};
                end
                INIT0: begin
                    state <= DONE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dat_loader.sv
// tb_dat_loader: directed vector bench for dat_loader with a simple echoing
// card model; a second instance covers the short no-verify configuration.
module tb_dat_loader;
    logic        e = 1'b0;
    logic        _reset;
    logic        start, start4;
    logic [11:0] task_id;
    logic        mmu_en, crm_en;
    logic [7:0]  src_data, src_data4;
    logic        src_valid, src_valid4;
    logic        src_ready, src_ready4;
    logic [15:0] address_cpu, address_cpu4;
    logic        r_w_cpu, r_w_cpu4;
    logic [7:0]  data_wr, data_wr4;
    logic [7:0]  data_rd, data_rd4;
    logic        busy, busy4, done, done4, error, error4;
    logic [3:0]  fail_index, fail_index4;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] mem [256];

    always #5 e = ~e;

    dat_loader #(.ENTRIES(16), .VERIFY(1'b1)) u16 (
        .e(e), ._reset(_reset), .start(start), .task_id(task_id),
        .mmu_en(mmu_en), .crm_en(crm_en), .src_data(src_data),
        .src_valid(src_valid), .src_ready(src_ready),
        .address_cpu(address_cpu), .r_w_cpu(r_w_cpu), .data_wr(data_wr),
        .data_rd(data_rd), .busy(busy), .done(done), .error(error),
        .fail_index(fail_index)
    );

    dat_loader #(.ENTRIES(4), .VERIFY(1'b0)) u4 (
        .e(e), ._reset(_reset), .start(start4), .task_id(task_id),
        .mmu_en(mmu_en), .crm_en(crm_en), .src_data(src_data4),
        .src_valid(src_valid4), .src_ready(src_ready4),
        .address_cpu(address_cpu4), .r_w_cpu(r_w_cpu4), .data_wr(data_wr4),
        .data_rd(data_rd4), .busy(busy4), .done(done4), .error(error4),
        .fail_index(fail_index4)
    );

    typedef struct {
        logic [11:0] tsk;
        logic        mmu;
        logic        crm;
        logic [7:0]  base;
        logic [4:0]  bad;
        int          stall_idx;
        int          stall_len;
        int          exp_done;
        int          exp_err;
        int          exp_fi;
        int          exp_wr;
        int          exp_rd;
        bit          hold;
    } vec_t;

    typedef struct {
        logic [15:0] addr;
        logic        rw;
        logic [7:0]  data;
    } bus_t;

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic run_vec(input int id, input vec_t v);
        logic [23:0] exp_w [$];
        logic [23:0] got_w [$];
        int cyc = 0, busy_n = 0, wr_n = 0, rd_n = 0, cnt = 0, stalled = 0;
        int err_d = -1, fi_d = -1, busy_d = -1;
        bit idle_ok = 1'b1;
        bit seen = 1'b0;
        int bad_at = -1;
        exp_w.push_back({16'hFF91, 3'b100, v.tsk[4:0]});
        exp_w.push_back({16'hFF97, 1'b0, v.tsk[11:5]});
        for (int i = 0; i < 16; i++)
            exp_w.push_back({12'hFFA, 4'(i), v.base + 8'(i)});
        if (v.bad[4]) begin
            exp_w.push_back({16'hFF91, 3'b000, v.tsk[4:0]});
            exp_w.push_back({16'hFF97, 1'b0, v.tsk[11:5]});
            exp_w.push_back({16'hFF90, 1'b0, v.mmu, 2'b00, v.crm, 3'b000});
        end
        for (int a = 0; a < 256; a++) mem[a] = 8'hEE;
        repeat (2) @(negedge e);
        task_id = v.tsk; mmu_en = v.mmu; crm_en = v.crm;
        src_valid = 1'b1; src_data = v.base;
        start = 1'b1;
        @(posedge e);
        while (!seen && cyc < 200) begin
            @(negedge e);
            cyc++;
            if (!v.hold) start = 1'b0;
            if (done) begin
                seen = 1'b1; err_d = error; fi_d = fail_index; busy_d = busy;
            end else if (busy) busy_n++;
            if (!r_w_cpu) begin
                wr_n++;
                got_w.push_back({address_cpu, data_wr});
                mem[address_cpu[7:0]] = data_wr;
            end else if (address_cpu != 16'h0000) rd_n++;
            if (src_ready) begin
                if (address_cpu != 16'h0000 || !r_w_cpu) idle_ok = 1'b0;
                if (cnt == v.stall_idx && stalled < v.stall_len) begin
                    src_valid = 1'b0; stalled++;
                end else src_valid = 1'b1;
                src_data = v.base + 8'(cnt);
                if (src_valid) cnt++;
            end
            if (!v.bad[4] && address_cpu == {12'hFFA, v.bad[3:0]})
                data_rd = 8'hFF;
            else
                data_rd = mem[address_cpu[7:0]];
        end
        chk($sformatf("v%0d done_cycle", id), cyc, v.exp_done);
        chk($sformatf("v%0d error", id), err_d, v.exp_err);
        chk($sformatf("v%0d fail_index", id), fi_d, v.exp_fi);
        chk($sformatf("v%0d busy_at_done", id), busy_d, 0);
        chk($sformatf("v%0d busy_cycles", id), busy_n, v.exp_done - 1);
        chk($sformatf("v%0d writes", id), wr_n, v.exp_wr);
        chk($sformatf("v%0d reads", id), rd_n, v.exp_rd);
        chk($sformatf("v%0d wait_idle", id), int'(idle_ok), 1);
        for (int i = 0; i < exp_w.size(); i++)
            if (bad_at < 0 && (i >= got_w.size() || got_w[i] != exp_w[i]))
                bad_at = i;
        if (got_w.size() != exp_w.size() && bad_at < 0) bad_at = exp_w.size();
        n_tests++;
        if (bad_at >= 0) begin
            n_fail++;
            $display("FAIL v%0d write_list: entry %0d got %0h expected %0h",
                     id, bad_at,
                     (bad_at < got_w.size()) ? got_w[bad_at] : 24'h0,
                     (bad_at < exp_w.size()) ? exp_w[bad_at] : 24'h0);
        end
    endtask

    vec_t vecs [6];
    vec_t v6;
    bus_t exp4 [13];

    initial begin
        int cnt4, k, dn;
        vecs[0] = '{12'h123, 1, 1, 8'h40, 5'h10, 0, 0, 54, 0, 0, 21, 16, 0};
        vecs[1] = '{12'h123, 1, 1, 8'h40, 5'h05, 0, 0, 41, 1, 5, 18, 6, 0};
        vecs[2] = '{12'h123, 1, 1, 8'h40, 5'h10, 7, 3, 57, 0, 0, 21, 16, 0};
        vecs[3] = '{12'hFFF, 0, 1, 8'hC0, 5'h0F, 0, 0, 51, 1, 15, 18, 16, 0};
        vecs[4] = '{12'h0A5, 1, 0, 8'h00, 5'h00, 0, 0, 36, 1, 0, 18, 1, 0};
        vecs[5] = '{12'h7C0, 0, 0, 8'h10, 5'h10, 0, 0, 54, 0, 0, 21, 16, 0};
        exp4[0]  = '{16'hFF91, 0, 8'h80};
        exp4[1]  = '{16'hFF97, 0, 8'h00};
        exp4[2]  = '{16'h0000, 1, 8'h00};
        exp4[3]  = '{16'hFFA0, 0, 8'h20};
        exp4[4]  = '{16'h0000, 1, 8'h00};
        exp4[5]  = '{16'hFFA1, 0, 8'h21};
        exp4[6]  = '{16'h0000, 1, 8'h00};
        exp4[7]  = '{16'hFFA2, 0, 8'h22};
        exp4[8]  = '{16'h0000, 1, 8'h00};
        exp4[9]  = '{16'hFFA3, 0, 8'h23};
        exp4[10] = '{16'hFF91, 0, 8'h00};
        exp4[11] = '{16'hFF97, 0, 8'h00};
        exp4[12] = '{16'hFF90, 0, 8'h48};

        _reset = 1'b0; start = 1'b0; start4 = 1'b0;
        task_id = 12'h0; mmu_en = 1'b0; crm_en = 1'b0;
        src_data = 8'h0; src_valid = 1'b0; data_rd = 8'h0;
        src_data4 = 8'h0; src_valid4 = 1'b1; data_rd4 = 8'h0;
        repeat (3) @(negedge e);
        chk("rst addr", address_cpu, 16'h0000);
        chk("rst r_w", r_w_cpu, 1);
        chk("rst data_wr", data_wr, 0);
        chk("rst flags", {src_ready, busy, done, error}, 0);
        chk("rst fail_index", fail_index, 0);
        chk("rst u4 flags", {src_ready4, busy4, done4, r_w_cpu4}, 1);
        _reset = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Four-entry window without read-back.
        repeat (2) @(negedge e);
        task_id = 12'h000; mmu_en = 1'b1; crm_en = 1'b1;
        cnt4 = 0;
        start4 = 1'b1;
        @(posedge e);
        for (int c = 1; c <= 14; c++) begin
            @(negedge e);
            start4 = 1'b0;
            if (c < 14) begin
                chk($sformatf("t4 c%0d bus", c),
                    {address_cpu4, r_w_cpu4, data_wr4},
                    {exp4[c-1].addr, exp4[c-1].rw, exp4[c-1].data});
            end else begin
                chk("t4 done", {done4, busy4}, 2'b10);
            end
            if (src_ready4) begin
                src_data4 = 8'h20 + 8'(cnt4);
                cnt4++;
            end
        end

        // Reset during the write of entry 9 abandons the sequence.
        repeat (2) @(negedge e);
        task_id = 12'h123; mmu_en = 1'b1; crm_en = 1'b1;
        src_valid = 1'b1; src_data = 8'h40;
        start = 1'b1;
        @(posedge e);
        k = 0;
        while (k < 100 && !(r_w_cpu == 1'b0 && address_cpu == 16'hFFA9)) begin
            @(negedge e);
            start = 1'b0;
            k++;
        end
        chk("t5 reached FFA9", int'(k < 100), 1);
        _reset = 1'b0;
        @(negedge e);
        chk("t5 idle bus", {address_cpu, r_w_cpu, data_wr}, {16'h0000, 1'b1, 8'h00});
        chk("t5 flags", {busy, done, src_ready}, 0);
        _reset = 1'b1;
        dn = 0;
        repeat (5) begin
            @(negedge e);
            if (done || busy) dn++;
        end
        chk("t5 no done after reset", dn, 0);
        run_vec(10, vecs[0]);

        // Start held high across a failing run, then re-accepted after DONE.
        v6 = vecs[1];
        v6.hold = 1'b1;
        run_vec(11, v6);
        @(negedge e);
        chk("t6 idle after done", {busy, r_w_cpu, error}, 3'b011);
        @(negedge e);
        chk("t6 restart", {busy, error, r_w_cpu, address_cpu},
            {1'b1, 1'b0, 1'b0, 16'hFF91});
        start = 1'b0;
        _reset = 1'b0;
        @(negedge e);
        _reset = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
